// File: rtl/arb_pkg.sv
// Shared definitions for the data memory arbiter: FSM state encoding,
// master index constants and the hold-counter width helper.
package arb_pkg;

  // Arbiter FSM states; OWNx means master x drives data_memory this cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Master indices, as recorded in last_owner.
  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

  // Width needed to hold the values 0..max_hold.
  function automatic int hold_cnt_w(input int max_hold);
    return $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/arb_hold_counter.sv
// Hold counter for the arbiter: counts cycles of the current ownership,
// saturating at MAX_HOLD. clear forces 0 (idle), start forces 1 (a new
// ownership begins this edge), inc advances while ownership continues.
// expired flags that the owner has used its full MAX_HOLD budget.
module arb_hold_counter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = hold_cnt_w(MAX_HOLD)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             start,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_HOLD);

  // Count register: clear beats start beats saturating increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (start) begin
      count <= CNT_W'(1);
    end else if (inc && (count != MAX_CNT)) begin
      count <= count + CNT_W'(1);
    end
  end

  // Budget used up: the owner must hand over if the other master waits.
  always_comb begin
    expired = (count == MAX_CNT);
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Two-master arbiter in front of the single-port data_memory.
// Master 0 is the CPU data port, master 1 the DMA/debug master.
// Grants are registered FSM states; address/data routing and read-back
// are combinational from the current grant.
//
// Optional feature: define ARB_ROUND_ROBIN_EN to grant simultaneous
// requests from IDLE to the master that did not own memory last.
// Without it master 0 wins simultaneous requests from IDLE.
//
// Handshake: a master raises req with a/we/wd and holds all of them
// stable until it sees its gnt; the access happens in every cycle in
// which gnt is high (write commits at the edge ending that cycle, read
// data is valid combinationally in that cycle). Without gnt nothing of
// the master reaches memory.
module data_memory_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            m0_req,
  input  logic                            m0_we,
  input  logic [ADDR_W-1:0]               m0_a,
  input  logic [DATA_W-1:0]               m0_wd,
  output logic                            m0_gnt,
  output logic [DATA_W-1:0]               m0_rd,
  output logic                            cpu_stall,
  input  logic                            m1_req,
  input  logic                            m1_we,
  input  logic [ADDR_W-1:0]               m1_a,
  input  logic [DATA_W-1:0]               m1_wd,
  output logic                            m1_gnt,
  output logic [DATA_W-1:0]               m1_rd,
  output logic [ADDR_W-1:0]               mem_a,
  output logic                            mem_we,
  output logic [DATA_W-1:0]               mem_wd,
  input  logic [DATA_W-1:0]               mem_rd,
  output arb_state_t                      state_dbg,
  output logic [hold_cnt_w(MAX_HOLD)-1:0] hold_cnt_dbg
);

  localparam int CNT_W = hold_cnt_w(MAX_HOLD);

  arb_state_t       state;
  arb_state_t       state_nxt;
  arb_state_t       both_winner;
  logic             cnt_clear;
  logic             cnt_start;
  logic             cnt_inc;
  logic             expired;
  logic [CNT_W-1:0] hold_cnt;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner;

  // Remember which master owned memory most recently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner <= ARB_M1;
    end else if (state == OWN0) begin
      last_owner <= ARB_M0;
    end else if (state == OWN1) begin
      last_owner <= ARB_M1;
    end
  end

  // Simultaneous requests go to the master that did not own last.
  always_comb begin
    both_winner = (last_owner == ARB_M0) ? OWN1 : OWN0;
  end
`else
  // Fixed priority: the CPU wins simultaneous requests.
  always_comb begin
    both_winner = OWN0;
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: grant from IDLE, hand over on req drop or hold expiry.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (m0_req && m1_req) begin
          state_nxt = both_winner;
        end else if (m0_req) begin
          state_nxt = OWN0;
        end else if (m1_req) begin
          state_nxt = OWN1;
        end
      end
      OWN0: begin
        if (!m0_req) begin
          state_nxt = m1_req ? OWN1 : IDLE;
        end else if (m1_req && expired) begin
          state_nxt = OWN1;
        end
      end
      OWN1: begin
        if (!m1_req) begin
          state_nxt = m0_req ? OWN0 : IDLE;
        end else if (m0_req && expired) begin
          state_nxt = OWN0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter control: zero in IDLE, 1 on each new ownership, else count on.
  always_comb begin
    cnt_clear = (state_nxt == IDLE);
    cnt_start = !cnt_clear && (state_nxt != state);
    cnt_inc   = !cnt_clear && !cnt_start;
  end

  arb_hold_counter #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) u_hold_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .start   (cnt_start),
    .inc     (cnt_inc),
    .count   (hold_cnt),
    .expired (expired)
  );

  // Outputs: grants from state, routing and read-back from the grant.
  always_comb begin
    m0_gnt       = (state == OWN0);
    m1_gnt       = (state == OWN1);
    cpu_stall    = m0_req & ~m0_gnt;
    mem_a        = m1_gnt ? m1_a : m0_a;
    mem_wd       = m1_gnt ? m1_wd : m0_wd;
    mem_we       = (m0_gnt & m0_we) | (m1_gnt & m1_we);
    m0_rd        = m0_gnt ? mem_rd : '0;
    m1_rd        = m1_gnt ? mem_rd : '0;
    state_dbg    = state;
    hold_cnt_dbg = hold_cnt;
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter with a behavioural data_memory model.
module tb_data_memory_arbiter;
  import arb_pkg::*;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_HOLD = 8;
  localparam int CNT_W    = hold_cnt_w(MAX_HOLD);

  logic              clk;
  logic              reset;
  logic              m0_req, m0_we, m1_req, m1_we;
  logic [ADDR_W-1:0] m0_a, m1_a, mem_a;
  logic [DATA_W-1:0] m0_wd, m1_wd, m0_rd, m1_rd, mem_wd, mem_rd;
  logic              m0_gnt, m1_gnt, cpu_stall, mem_we;
  arb_state_t        state_dbg;
  logic [CNT_W-1:0]  hold_cnt_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_val;

  // Memory model: 64 words, word-addressed by a[7:2].
  logic              mem_init;
  logic [DATA_W-1:0] ram [0:63];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'(i) * 32'h0101_0101;
    end else if (mem_we) begin
      ram[mem_a[7:2]] <= mem_wd;
    end
  end
  assign mem_rd = ram[mem_a[7:2]];

  data_memory_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_a(m0_a), .m0_wd(m0_wd),
    .m0_gnt(m0_gnt), .m0_rd(m0_rd), .cpu_stall(cpu_stall),
    .m1_req(m1_req), .m1_we(m1_we), .m1_a(m1_a), .m1_wd(m1_wd),
    .m1_gnt(m1_gnt), .m1_rd(m1_rd),
    .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .state_dbg(state_dbg), .hold_cnt_dbg(hold_cnt_dbg)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Wait up to budget negedges for the selected master's grant.
  task automatic wait_gnt(input bit which, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((which ? m1_gnt : m0_gnt) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
      n_fail++; $display("FAIL reset_gnt: got m0=%b m1=%b expected 0 0", m0_gnt, m1_gnt);
    end
    n_tests++;
    if (cpu_stall !== 1'b1) begin
      n_fail++; $display("FAIL reset_stall: got %b expected 1", cpu_stall);
    end
    n_tests++;
    if (mem_we !== 1'b0) begin
      n_fail++; $display("FAIL reset_mem_we: got %b expected 0", mem_we);
    end
    n_tests++;
    if (state_dbg !== IDLE || hold_cnt_dbg !== '0) begin
      n_fail++; $display("FAIL reset_state: got state=%0d cnt=%0d expected 0 0", state_dbg, hold_cnt_dbg);
    end
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (m0_gnt !== 1'b1 || cpu_stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: got gnt=%b stall=%b expected 1 0", m0_gnt, cpu_stall);
    end
  endtask

  // M0 (already granted) writes DEADBEEF to 8, then M1 reads it back.
  task automatic test_write_read();
    m0_we = 1'b1; m0_a = 32'd8; m0_wd = 32'hDEAD_BEEF;
    #1;
    n_tests++;
    if (mem_we !== 1'b1 || mem_a !== 32'd8 || mem_wd !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL wr_route: got we=%b a=%h wd=%h expected 1 8 deadbeef", mem_we, mem_a, mem_wd);
    end
    @(negedge clk);
    m0_req = 1'b0; m0_we = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_a = 32'd8;
    exp_q.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    n_tests++;
    if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin
      n_fail++; $display("FAIL rd_handover: got m0=%b m1=%b expected 0 1", m0_gnt, m1_gnt);
    end
    n_tests++;
    exp_val = exp_q.pop_front();
    if (m1_rd !== exp_val) begin
      n_fail++; $display("FAIL rd_data: got %h expected %h", m1_rd, exp_val);
    end
    n_tests++;
    if (m0_rd !== '0) begin
      n_fail++; $display("FAIL rd_m0_zero: got %h expected 0", m0_rd);
    end
    m1_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if (state_dbg !== IDLE) begin
      n_fail++; $display("FAIL rd_to_idle: got state %0d expected 0", state_dbg);
    end
  endtask

  task automatic test_simultaneous();
    logic exp_m1;
    reset = 1'b1; #1; reset = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b0; m1_we = 1'b0;
    @(negedge clk);
    n_tests++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      n_fail++; $display("FAIL simul_first: got m0=%b m1=%b expected 1 0", m0_gnt, m1_gnt);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
    m0_req = 1'b1; m1_req = 1'b1;
    @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
    exp_m1 = 1'b1;
`else
    exp_m1 = 1'b0;
`endif
    n_tests++;
    if (m1_gnt !== exp_m1 || m0_gnt !== ~exp_m1) begin
      n_fail++; $display("FAIL simul_second: got m0=%b m1=%b expected %b %b", m0_gnt, m1_gnt, ~exp_m1, exp_m1);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
  endtask

  // M1 holds req, M0 requests in M1's first grant cycle.
  task automatic test_max_hold();
    int stall_cnt;
    m1_req = 1'b1; m1_a = 32'd8; m1_we = 1'b0;
    @(negedge clk);
    n_tests++;
    if (m1_gnt !== 1'b1) begin
      n_fail++; $display("FAIL hold_first_gnt: got %b expected 1", m1_gnt);
    end
    m0_req = 1'b1; m0_a = 32'd0; m0_we = 1'b0;
    stall_cnt = 0;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (m0_gnt === 1'b1) break;
      if (cpu_stall === 1'b1) stall_cnt++;
      exp_q.push_back(32'hDEAD_BEEF);
      exp_val = exp_q.pop_front();
      n_tests++;
      if (m1_gnt !== 1'b1 || m1_rd !== exp_val) begin
        n_fail++; $display("FAIL hold_m1_cycle%0d: got gnt=%b rd=%h expected 1 %h", i, m1_gnt, m1_rd, exp_val);
      end
      @(negedge clk);
      #1;
    end
    n_tests++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      n_fail++; $display("FAIL hold_handover: got m0=%b m1=%b expected 1 0", m0_gnt, m1_gnt);
    end
    n_tests++;
    if (stall_cnt != MAX_HOLD || cpu_stall !== 1'b0) begin
      n_fail++; $display("FAIL hold_stall_cycles: got %0d stall=%b expected %0d 0", stall_cnt, cpu_stall, MAX_HOLD);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ungranted_write();
    m0_req = 1'b1; m0_we = 1'b0; m0_a = 32'd0;
    @(negedge clk);
    m1_req = 1'b1; m1_we = 1'b1; m1_a = 32'd4; m1_wd = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++;
      if (mem_we !== 1'b0 || m1_gnt !== 1'b0) begin
        n_fail++; $display("FAIL ungnt_we_cycle%0d: got we=%b gnt=%b expected 0 0", i, mem_we, m1_gnt);
      end
      @(negedge clk);
    end
    m1_req = 1'b0; m1_we = 1'b0; m0_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if (ram[1] !== 32'h0101_0101) begin
      n_fail++; $display("FAIL ungnt_ram1: got %h expected 01010101", ram[1]);
    end
  endtask

  task automatic test_reset_mid_burst();
    m1_req = 1'b1; m1_we = 1'b1; m1_a = 32'd12; m1_wd = 32'hCAFE_0001;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (m1_gnt !== 1'b1 || mem_we !== 1'b1) begin
      n_fail++; $display("FAIL burst_gnt: got gnt=%b we=%b expected 1 1", m1_gnt, mem_we);
    end
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (m1_gnt !== 1'b0 || m0_gnt !== 1'b0 || mem_we !== 1'b0 || state_dbg !== IDLE) begin
      n_fail++; $display("FAIL burst_async_reset: got m0=%b m1=%b we=%b st=%0d expected 0 0 0 0", m0_gnt, m1_gnt, mem_we, state_dbg);
    end
    #1 reset = 1'b0;
    m1_we = 1'b0;
    @(negedge clk);
    n_tests++;
    if (m1_gnt !== 1'b1) begin
      n_fail++; $display("FAIL burst_restart: got %b expected 1", m1_gnt);
    end
    m1_req = 1'b0;
    @(negedge clk);
  endtask

  // Random write by M0 followed by read-back by M1.
  task automatic test_back_to_back();
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    bit ok;
    for (int k = 0; k < 6; k++) begin
      addr = 32'($urandom_range(16, 63)) << 2;
      data = $urandom;
      m0_req = 1'b1; m0_we = 1'b1; m0_a = addr; m0_wd = data;
      wait_gnt(1'b0, 4, ok);
      n_tests++;
      if (!ok) begin
        n_fail++; $display("FAIL b2b_wr_gnt%0d: got no grant expected grant within 4 cycles", k);
      end
      @(negedge clk);
      m0_req = 1'b0; m0_we = 1'b0;
      m1_req = 1'b1; m1_we = 1'b0; m1_a = addr;
      exp_q.push_back(data);
      wait_gnt(1'b1, 4, ok);
      exp_val = exp_q.pop_front();
      n_tests++;
      if (!ok || m1_rd !== exp_val) begin
        n_fail++; $display("FAIL b2b_rd%0d: got gnt=%b rd=%h expected 1 %h", k, ok, m1_rd, exp_val);
      end
      m1_req = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; mem_init = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_a = '0; m0_wd = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_a = '0; m1_wd = '0;
    @(negedge clk);
    mem_init = 1'b0;
    test_reset();
    test_write_read();
    test_simultaneous();
    test_max_hold();
    test_ungranted_write();
    test_reset_mid_burst();
    test_back_to_back();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Two-master arbiter that shares the single-port `data_memory` between the CPU data port (master 0) and a DMA/debug master (master 1). It sits between the masters and `data_memory` and routes one master's address, write-enable and write-data to memory per cycle. It returns read data to the granted master and raises a stall for the CPU while the CPU is locked out. Grants are registered; routing and read-back are combinational within the grant cycle.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `MAX_HOLD`, 8, maximum consecutive cycles one master keeps the grant while the other requests; must be ≥1.

- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `m0_req` input 1: CPU requests memory.
- `m0_we` input 1: CPU write enable.
- `m0_a` input ADDR_W: CPU address.
- `m0_wd` input DATA_W: CPU write data.
- `m0_gnt` output 1: CPU owns memory this cycle.
- `m0_rd` output DATA_W: read data to CPU.
- `cpu_stall` output 1: `m0_req & ~m0_gnt`; freezes the PC `d_flop`.
- `m1_req`, `m1_we`, `m1_a`, `m1_wd`, `m1_gnt`, `m1_rd`: same for master 1.
- `mem_a` output ADDR_W: to `data_memory.a`.
- `mem_we` output 1: to `data_memory.we`.
- `mem_wd` output DATA_W: to `data_memory.wd`.
- `mem_rd` input DATA_W: from `data_memory.rd`.

## Operation
- States: IDLE, OWN0, OWN1. `m0_gnt`=(state==OWN0), `m1_gnt`=(state==OWN1); at most one grant is high.
- IDLE: no request stays in IDLE. A single requester goes to its OWN state. If both request, the winner is set by the policy (see Configuration).
- OWNx, owner keeps `req` high, other idle: stay; hold counter saturates at MAX_HOLD.
- OWNx, owner keeps `req` high, other requesting:
  - Counter increments each cycle.
  - When counter reaches MAX_HOLD, go directly to OWN(other) with no idle cycle.
  - Counter resets to 1 on every ownership change.
- OWNx, owner drops `req`: go to OWN(other) if the other requests, else IDLE. The counter is cleared on IDLE.
- Routing:
  - `mem_a`/`mem_wd` come from the granted master.
  - `mem_we` = `gnt_x & mx_we`; it is forced 0 in IDLE and for the ungranted master.
  - In IDLE, `mem_a`/`mem_wd` come from master 0 (don't-care, but deterministic).
- Read-back:
  - `m0_rd` = `mem_rd` while `m0_gnt`, else 0.
  - `m1_rd` follows the same rule with `m1_gnt`.
- A master must hold `req`, `a`, `we` and `wd` stable until it sees its `gnt`. An ungranted master's write is never performed.
- `last_owner` register: records the most recent OWN state; used only by the round-robin policy.

## Timing
- Reset values: state IDLE, both `gnt` = 0, `cpu_stall` = `m0_req`, `mem_we` = 0, counter 0, `last_owner` = 1 (so master 0 wins first).
- `req` is sampled at the rising edge. `gnt` rises one cycle after the request is first seen, so there is 1 cycle of arbitration latency from IDLE.
- A write commits at the rising edge that ends a cycle with `gnt` & `we`. Read data is valid combinationally in any cycle with `gnt`.
- Handover on `req` drop or MAX_HOLD expiry takes 0 gap cycles: old `gnt` falls and new `gnt` rises on the same edge.
- Worst-case wait for a requester while the other holds is MAX_HOLD cycles plus 1.
- Reset asserted mid-transfer clears `gnt` and `mem_we` immediately, asynchronously. Any write in that cycle is not guaranteed.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: simultaneous requests from IDLE are granted to the master that is not `last_owner`.
- `ARB_ROUND_ROBIN_EN` not defined: fixed priority; master 0 wins simultaneous requests from IDLE and `last_owner` is unused.
- The MAX_HOLD rotation applies in both builds.

## Structure
- A shared package `arb_pkg` holds:
  - state encoding constants: IDLE=2'd0, OWN0=2'd1, OWN1=2'd2;
  - master index constants `ARB_M0`, `ARB_M1`;
  - the hold-counter width function `$clog2(MAX_HOLD+1)`.
- One sub-module, `arb_hold_counter`: clear, increment and saturate at MAX_HOLD, with a `expired` output.
- Muxing and the FSM stay in the top module.

## Test plan
- Reset with `m0_req`=1 → `m0_gnt`=0, `cpu_stall`=1, `mem_we`=0; after release, `m0_gnt`=1 on the next edge and `cpu_stall`=0.
- M0 writes 32'hDEADBEEF to address 8; then M1 reads address 8 → `m1_rd`=32'hDEADBEEF in its first grant cycle; `m0_rd`=0 during that cycle.
- Both request from IDLE, first time after reset → M0 wins in both builds. Repeat after M0 was last owner → with `ARB_ROUND_ROBIN_EN`, M1 wins; without the macro, M0 wins.
- MAX_HOLD=8, M1 holds `req` and M0 requests → M1 keeps the grant for 8 cycles, then `m0_gnt` rises on the same edge `m1_gnt` falls; `cpu_stall` is high for exactly 8 cycles.
- M1 `we`=1 at address 4 while ungranted → `data_memory.ram[1]` is unchanged and `mem_we`=0 throughout.
- `reset` pulses mid-way through an M1 burst → both `gnt` drop asynchronously, state is IDLE, and arbitration restarts with 1-cycle latency.
